blk_6a71ee: RTL and testbench

Shares the reconfig CPU's single-port on-chip debug memory (OCI RAM) between two requesters: the JTAG debug slave's system-clock action strobes and the CPU data master's Avalon-MM debug-memory slave. JTAG strobes cannot be stalled, so they are captured in a one-entry pending slot. Avalon requests are held off with waitrequest, and simultaneous demand is resolved by alternating grants. The block also owns the JTAG auto-incrementing address pointer and the MonDReg readback register.

---
 rtl/blk_6a71ee.sv | 88 ++++++++
 tb/tb_blk_6a71ee.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/blk_6a71ee.sv
// blk_6a71ee: arbitrates the OCI debug RAM between JTAG action strobes and an Avalon-MM slave,
// and owns the JTAG auto-increment address pointer and the MonDReg readback register.
module blk_6a71ee #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] avl_address,
    input  logic              avl_read,
    input  logic              avl_write,
    input  logic [DATA_W-1:0] avl_writedata,
    output logic              avl_waitrequest,
    output logic              avl_readdatavalid,
    output logic [DATA_W-1:0] avl_readdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {TAG_NONE, TAG_JTAG, TAG_AVL} tag_t;
    tag_t              tag, tag_nxt;
    logic              pend, slot_we, last_avl;
    logic [ADDR_W-1:0] slot_addr, jtag_addr, jtag_addr_nxt, load_addr, addr_q;
    logic [DATA_W-1:0] slot_data, wdata_q;
    logic              avl_req, grant_j, grant_a, load;

    always_comb begin
        avl_req           = avl_read | avl_write;
        // on a tie the side that did not win last time gets the RAM
        grant_j           = ~reset & pend & (~avl_req | last_avl);
        grant_a           = ~reset & avl_req & ~grant_j;
        load_addr         = take_action_ocimem_a ? jdo[ADDR_W+16:17] : jtag_addr;
        load              = take_no_action_ocimem_a | take_action_ocimem_b | (take_action_ocimem_a & jdo[14]);
        jtag_addr_nxt     = load ? load_addr + ADDR_W'(1) : load_addr;
        mem_re            = grant_j ? ~slot_we : grant_a & avl_read;
        mem_we            = grant_j ? slot_we : grant_a & avl_write;
        mem_addr          = grant_j ? slot_addr : grant_a ? avl_address : addr_q;
        mem_wdata         = grant_j ? slot_data : grant_a ? avl_writedata : wdata_q;
        avl_waitrequest   = avl_req & ~grant_a;
        avl_readdatavalid = (tag == TAG_AVL) & ~reset;
        avl_readdata      = avl_readdatavalid ? mem_rdata : '0;
        tag_nxt           = mem_re ? (grant_j ? TAG_JTAG : TAG_AVL) : TAG_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) tag <= TAG_NONE;
        else tag <= tag_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend         <= 1'b0;
            slot_we      <= 1'b0;
            slot_addr    <= '0;
            slot_data    <= '0;
            jtag_addr    <= '0;
            last_avl     <= 1'b1;
            jtag_overrun <= 1'b0;
            MonDReg      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            jtag_addr <= jtag_addr_nxt;
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            if (grant_j) last_avl <= 1'b0;
            else if (grant_a) last_avl <= 1'b1;
            if (load) begin
                pend      <= 1'b1;
                slot_we   <= take_action_ocimem_b;
                slot_addr <= load_addr;
                slot_data <= jdo[34:3];
                if (pend & ~grant_j) jtag_overrun <= 1'b1;
            end else if (grant_j) begin
                pend <= 1'b0;
            end
            if (tag == TAG_JTAG) MonDReg <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_blk_6a71ee.sv
// tb_blk_6a71ee: directed and randomized checks of blk_6a71ee against a transaction-level model
// with its own copy of the RAM contents.
module tb_blk_6a71ee;
    logic        clk = 0, reset = 1;
    logic        ta_a = 0, tna = 0, tb = 0;
    logic [37:0] jdo = '0;
    logic [31:0] MonDReg;
    logic        jtag_overrun;
    logic [7:0]  avl_address = '0;
    logic        avl_read = 0, avl_write = 0;
    logic [31:0] avl_writedata = '0;
    logic        avl_waitrequest, avl_readdatavalid;
    logic [31:0] avl_readdata;
    logic [7:0]  mem_addr;
    logic        mem_re, mem_we;
    logic [31:0] mem_wdata, mem_rdata = '0;

    int total = 0, bad = 0;
    logic [31:0] ram [256];
    logic [31:0] ref_mem [256];
    bit acc = 0;

    // model state
    bit          m_pend = 0, m_swe = 0, m_last_avl = 1, m_ovr = 0;
    logic [7:0]  m_saddr = '0, m_jaddr = '0;
    logic [31:0] m_sdata = '0, m_mon = '0, m_infdata = '0;
    int          m_inf = 0;

    blk_6a71ee dut (
        .clk(clk), .reset(reset),
        .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna), .take_action_ocimem_b(tb),
        .jdo(jdo), .MonDReg(MonDReg), .jtag_overrun(jtag_overrun),
        .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
        .avl_writedata(avl_writedata), .avl_waitrequest(avl_waitrequest),
        .avl_readdatavalid(avl_readdatavalid), .avl_readdata(avl_readdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) acc = (avl_read || avl_write) && !avl_waitrequest;

    always @(negedge clk) begin : cmp
        bit req, gj, ga, ere, ewe, erdv, was_pend;
        req = avl_read || avl_write;
        gj  = !reset && m_pend && (!req || m_last_avl);
        ga  = !reset && req && !gj;
        ere = gj ? !m_swe : (ga && avl_read);
        ewe = gj ? m_swe : (ga && avl_write);
        erdv = (m_inf == 2) && !reset;
        chk("mem_re", mem_re, ere);
        chk("mem_we", mem_we, ewe);
        if (ere || ewe) chk("mem_addr", mem_addr, gj ? m_saddr : avl_address);
        if (ewe) chk("mem_wdata", mem_wdata, gj ? m_sdata : avl_writedata);
        chk("waitrequest", avl_waitrequest, req && !ga);
        chk("readdatavalid", avl_readdatavalid, erdv);
        if (erdv) chk("readdata", avl_readdata, m_infdata);
        chk("MonDReg", MonDReg, m_mon);
        chk("overrun", jtag_overrun, m_ovr);
        if (reset) begin
            m_pend = 0; m_jaddr = '0; m_last_avl = 1; m_ovr = 0; m_mon = '0; m_inf = 0;
        end else begin
            if (m_inf == 1) m_mon = m_infdata;
            m_inf = 0;
            if (gj) begin
                if (m_swe) ref_mem[m_saddr] = m_sdata;
                else begin m_inf = 1; m_infdata = ref_mem[m_saddr]; end
                m_last_avl = 0;
            end else if (ga) begin
                if (avl_write) ref_mem[avl_address] = avl_writedata;
                else begin m_inf = 2; m_infdata = ref_mem[avl_address]; end
                m_last_avl = 1;
            end
            was_pend = m_pend && !gj;
            if (gj) m_pend = 0;
            if (ta_a) m_jaddr = jdo[24:17];
            if ((ta_a && jdo[14]) || tna || tb) begin
                if (was_pend) m_ovr = 1;
                m_pend = 1; m_swe = tb; m_saddr = m_jaddr; m_sdata = jdo[34:3];
                m_jaddr = m_jaddr + 8'd1;
            end
        end
    end

    task tick;
        @(posedge clk); #1;
        ta_a = 0; tna = 0; tb = 0;
    endtask
    task st_a(input logic [7:0] a, input bit rd);
        ta_a = 1; jdo = '0; jdo[24:17] = a; jdo[14] = rd;
    endtask
    task st_nb;
        tna = 1;
    endtask
    task st_b(input logic [31:0] d);
        tb = 1; jdo = '0; jdo[34:3] = d;
    endtask
    task do_reset;
        reset = 1; avl_read = 0; avl_write = 0;
        tick; tick;
        reset = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rnd;
        for (int i = 0; i < 256; i++) begin ram[i] = $urandom; ref_mem[i] = ram[i]; end
        ram[8'h20] = 32'h12345678; ref_mem[8'h20] = 32'h12345678;
        tick; tick;
        reset = 0;
        @(negedge clk);
        chk("rst MonDReg", MonDReg, 32'h0);
        chk("rst overrun", jtag_overrun, 0);
        chk("rst rdv", avl_readdatavalid, 0);
        chk("rst readdata", avl_readdata, 32'h0);
        // JTAG write then read back
        st_a(8'h10, 0); tick;
        st_b(32'hDEADBEEF); tick;
        st_a(8'h10, 1);
        @(negedge clk);
        chk("t1 we", mem_we, 1); chk("t1 waddr", mem_addr, 8'h10); chk("t1 wdata", mem_wdata, 32'hDEADBEEF);
        tick;
        @(negedge clk);
        chk("t1 re", mem_re, 1); chk("t1 raddr", mem_addr, 8'h10);
        tick; tick; tick;
        @(negedge clk);
        chk("t1 MonDReg", MonDReg, 32'hDEADBEEF);
        st_nb; tick;
        @(negedge clk);
        chk("t1 next addr", mem_addr, 8'h11);
        // pointer wrap
        st_a(8'hFF, 0); tick;
        st_nb; tick;
        @(negedge clk);
        chk("wrap re", mem_re, 1); chk("wrap addr ff", mem_addr, 8'hFF);
        st_nb; tick;
        @(negedge clk);
        chk("wrap addr 00", mem_addr, 8'h00);
        // contention: JTAG wins first tie after reset
        do_reset;
        st_a(8'h21, 0); tick;
        st_b(32'hCAFEF00D); tick;
        avl_read = 1; avl_address = 8'h20;
        @(negedge clk);
        chk("ct we", mem_we, 1); chk("ct addr21", mem_addr, 8'h21); chk("ct wait", avl_waitrequest, 1);
        tick;
        @(negedge clk);
        chk("ct wait0", avl_waitrequest, 0); chk("ct re", mem_re, 1); chk("ct addr20", mem_addr, 8'h20);
        tick;
        avl_read = 0;
        @(negedge clk);
        chk("ct rdv", avl_readdatavalid, 1); chk("ct rdata", avl_readdata, 32'h12345678);
        avl_read = 1;
        for (int i = 0; i < 6; i++) begin st_nb; tick; end
        avl_read = 0;
        // overrun while Avalon holds the grant
        do_reset;
        st_a(8'h30, 0); tick;
        avl_read = 1; avl_address = 8'h40;
        st_nb; tick;
        st_nb; tick;
        st_nb; tick;
        @(negedge clk);
        chk("ov flag", jtag_overrun, 1); chk("ov re", mem_re, 1); chk("ov addr", mem_addr, 8'h32);
        avl_read = 0;
        tick;
        // strobe in the same cycle the pending op issues
        do_reset;
        st_a(8'h50, 0); tick;
        st_nb; tick;
        st_nb;
        @(negedge clk);
        chk("sc addr50", mem_addr, 8'h50);
        tick;
        @(negedge clk);
        chk("sc addr51", mem_addr, 8'h51); chk("sc overrun", jtag_overrun, 0);
        // reset while a read is in flight
        do_reset;
        avl_read = 1; avl_address = 8'h20;
        @(negedge clk);
        chk("rr accept", avl_waitrequest, 0);
        tick;
        avl_read = 0; reset = 1;
        @(negedge clk);
        chk("rr rdv", avl_readdatavalid, 0); chk("rr rdata", avl_readdata, 32'h0);
        tick;
        reset = 0;
        @(negedge clk);
        chk("rr rdv2", avl_readdatavalid, 0); chk("rr MonDReg", MonDReg, 32'h0);
        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            tick;
            reset = ($urandom_range(0, 299) == 0);
            if ((!avl_read && !avl_write) || acc) begin
                r = $urandom_range(0, 9);
                avl_read = (r < 3);
                avl_write = (r >= 3 && r < 5);
                avl_address = 8'($urandom_range(0, 15));
                avl_writedata = $urandom;
            end
            r = $urandom_range(0, 9);
            rnd = {$urandom, $urandom};
            jdo = rnd[37:0];
            jdo[24:17] = 8'($urandom_range(0, 15));
            ta_a = (r < 2);
            tna = (r == 2 || r == 3);
            tb = (r == 4 || r == 5);
        end
        tick;
        avl_read = 0; avl_write = 0; reset = 0;
        tick; tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
